row_buffer_sequencer: RTL and testbench

// - Sequences the single-row temporary buffer of the vertical FIR stage: writes each incoming row of

---
 rtl/row_buffer_sequencer_pkg.sv | 21 ++
 rtl/rbs_pos_counter.sv | 44 ++++
 rtl/row_buffer_sequencer.sv | 177 +++++++++++++++++
 tb/tb_row_buffer_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_buffer_sequencer_pkg.sv
// Shared types and default widths for the vertical-FIR row buffer sequencer.
// MAX_RES_TARX is the project-wide buffer capacity in pixels.
`ifndef MAX_RES_TARX
`define MAX_RES_TARX 1919
`endif

package row_buffer_sequencer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PTR_W_DEF  = 11;
    localparam int ROW_W_DEF  = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_MID   = 3'd2,
        S_LAST  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

endpackage

// File: rtl/rbs_pos_counter.sv
// Column/row position tracker for one frame; the flags are decoded from the
// current position so the FSM can act on the pixel being accepted.
module rbs_pos_counter
    import row_buffer_sequencer_pkg::*;
#(
    parameter int PTR_W = PTR_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [PTR_W-1:0] line_len,
    input  logic [ROW_W-1:0] num_rows,
    output logic             col_last,
    output logic             row_next_last
);

    logic [PTR_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    // row_next_last: the row after the current one is the final row of the frame
    assign col_last      = (col_r == (line_len - PTR_W'(1)));
    assign row_next_last = (row_r == (num_rows - ROW_W'(2)));

    // Column wraps at line_len-1 and carries into the row count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (clear) begin
            col_r <= '0;
            row_r <= '0;
        end else if (advance) begin
            if (col_last) begin
                col_r <= '0;
                row_r <= row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/row_buffer_sequencer.sv
// Writes each row into the single-row buffer while reading the previous row
// back in lockstep, emitting aligned (previous, current) pixel pairs.
`ifndef MAX_RES_TARX
`define MAX_RES_TARX 1919
`endif

module row_buffer_sequencer
    import row_buffer_sequencer_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_RES_TARX = `MAX_RES_TARX,
    parameter int PTR_W        = PTR_W_DEF,
    parameter int ROW_W        = ROW_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [PTR_W-1:0]  line_len,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              buf_wr_en,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              buf_rd_en,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_cur,
    output logic [DATA_W-1:0] out_prev,
    output logic              out_col_last,
    output logic              out_row_last,
    output logic              frame_done,
    output logic              busy,
    output logic              cfg_err
);

    state_t           state_r;
    logic [PTR_W-1:0] len_r;
    logic [ROW_W-1:0] rows_r;
    logic [PTR_W-1:0] occ_r;
    logic             cfg_ok_s;
    logic             start_s;
    logic             accept_s;
    logic             streaming_s;
    logic             col_last_s;
    logic             row_next_last_s;

    assign cfg_ok_s    = (line_len != '0) && (line_len <= PTR_W'(MAX_RES_TARX)) &&
                         (num_rows >= ROW_W'(2));
    assign start_s     = (state_r == S_IDLE) && frame_start && cfg_ok_s;
    assign streaming_s = (state_r == S_MID) || (state_r == S_LAST);
    assign accept_s    = in_valid && in_ready;
    assign busy        = (state_r != S_IDLE);
    assign buf_wr_data = in_data;
    // Gated so a reset or idle output never shows stale buffer contents
    assign out_prev    = out_valid ? buf_rd_data : '0;

    // Input handshake and buffer strobes; a mid-frame frame_start blocks the accept
    always_comb begin
        in_ready  = 1'b0;
        buf_wr_en = 1'b0;
        buf_rd_en = 1'b0;
        case (state_r)
            S_FIRST: begin
                in_ready  = !frame_start;
                buf_wr_en = in_valid && !frame_start;
            end
            S_MID: begin
                in_ready  = !frame_start && (!out_valid || out_ready);
                buf_wr_en = in_valid && in_ready;
                buf_rd_en = in_valid && in_ready;
            end
            S_LAST: begin
                in_ready  = !frame_start && (!out_valid || out_ready);
                buf_rd_en = in_valid && in_ready;
            end
            S_FLUSH: begin
                buf_rd_en = (occ_r != '0);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    rbs_pos_counter #(
        .PTR_W (PTR_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .clk           (clk),
        .rst           (rst),
        .clear         (start_s),
        .advance       (accept_s),
        .line_len      (len_r),
        .num_rows      (rows_r),
        .col_last      (col_last_s),
        .row_next_last (row_next_last_s)
    );

    // Sequencer FSM, occupancy counter and output pair register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            len_r        <= '0;
            rows_r       <= '0;
            occ_r        <= '0;
            out_valid    <= 1'b0;
            out_cur      <= '0;
            out_col_last <= 1'b0;
            out_row_last <= 1'b0;
            frame_done   <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            case ({buf_wr_en, buf_rd_en})
                2'b10:   occ_r <= occ_r + PTR_W'(1);
                2'b01:   occ_r <= occ_r - PTR_W'(1);
                default: occ_r <= occ_r;
            endcase

            if (accept_s && streaming_s) begin
                out_valid    <= 1'b1;
                out_cur      <= in_data;
                out_col_last <= col_last_s;
                out_row_last <= (state_r == S_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_r)
                S_IDLE: begin
                    if (frame_start) begin
                        if (cfg_ok_s) begin
                            len_r   <= line_len;
                            rows_r  <= num_rows;
                            cfg_err <= 1'b0;
                            state_r <= S_FIRST;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_FIRST, S_MID, S_LAST: begin
                    if (frame_start) begin
                        cfg_err   <= 1'b1;
                        out_valid <= 1'b0;
                        state_r   <= S_FLUSH;
                    end else if (accept_s && col_last_s) begin
                        if (state_r == S_LAST) begin
                            frame_done <= 1'b1;
                            state_r    <= S_IDLE;
                        end else if (row_next_last_s) begin
                            state_r <= S_LAST;
                        end else begin
                            state_r <= S_MID;
                        end
                    end
                end
                S_FLUSH: begin
                    if (frame_start) begin
                        cfg_err <= 1'b1;
                    end
                    if (occ_r == '0) begin
                        frame_done <= 1'b1;
                        state_r    <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_buffer_sequencer.sv
// Directed bench for row_buffer_sequencer with a behavioural row buffer
// (FIFO with one-cycle read latency) and hand-computed pixel pairs.
module tb_row_buffer_sequencer;

    localparam int MAXR = 1919;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [10:0] line_len;
    logic [10:0] num_rows;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        buf_wr_en;
    logic [7:0]  buf_wr_data;
    logic        buf_rd_en;
    logic [7:0]  buf_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_cur;
    logic [7:0]  out_prev;
    logic        out_col_last;
    logic        out_row_last;
    logic        frame_done;
    logic        busy;
    logic        cfg_err;

    int n_assert = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    int occ_max  = 0;
    int underflow = 0;
    logic [7:0]  bufq[$];
    logic [17:0] obs[$];

    always #5 clk = ~clk;

    row_buffer_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .line_len     (line_len),
        .num_rows     (num_rows),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_data  (buf_wr_data),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_data  (buf_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cur      (out_cur),
        .out_prev     (out_prev),
        .out_col_last (out_col_last),
        .out_row_last (out_row_last),
        .frame_done   (frame_done),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    // Row buffer model: read data appears one cycle after buf_rd_en and holds otherwise
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bufq.delete();
            buf_rd_data <= 8'h00;
        end else begin
            if (buf_rd_en) begin
                if (bufq.size() > 0) buf_rd_data <= bufq.pop_front();
                else begin
                    underflow++;
                    buf_rd_data <= 8'hEE;
                end
            end
            if (buf_wr_en) bufq.push_back(buf_wr_data);
        end
    end

    // Observation on the falling edge: accepted pairs, reads, done pulses, occupancy peak
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready)
                obs.push_back({out_prev, out_cur, out_col_last, out_row_last});
            if (buf_rd_en) rd_cnt++;
            if (frame_done) done_cnt++;
            if (int'(dut.occ_r) > occ_max) occ_max = int'(dut.occ_r);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(10 * (r + 1) + c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic start(input logic [10:0] len, input logic [10:0] rows);
        frame_start = 1'b1;
        line_len    = len;
        num_rows    = rows;
        @(posedge clk); #1;
        frame_start = 1'b0;
        line_len    = 11'd0;
        num_rows    = 11'd0;
    endtask

    task automatic send_row(input int r, input int len);
        for (int c = 0; c < len; c++) push(pix(r, c));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_pairs(input int len, input int rows, input int n);
        int r;
        int c;
        chk("pair_count", obs.size(), n);
        for (int k = 0; k < n && k < obs.size(); k++) begin
            r = k / len + 1;
            c = k % len;
            chk($sformatf("pair%0d", k), 32'(obs[k]),
                32'({pix(r - 1, c), pix(r, c), (c == len - 1), (r == rows - 1)}));
        end
    endtask

    initial begin
        int errs;
        rst = 1'b1; frame_start = 1'b0; line_len = 11'd0; num_rows = 11'd0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_outputs", {in_ready, buf_wr_en, buf_rd_en, out_valid, out_cur, out_prev,
            out_col_last, out_row_last, frame_done, busy, cfg_err}, 32'd0);
        chk("rst_occ", 32'(dut.occ_r), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame: 4 x 3, free-running output
        obs.delete(); done_cnt = 0;
        start(11'd4, 11'd3);
        for (int r = 0; r < 3; r++) send_row(r, 4);
        wait_idle("f1_idle");
        check_pairs(4, 3, 8);
        chk("f1_done_cnt", done_cnt, 1);
        chk("f1_occ_end", 32'(dut.occ_r), 32'd0);
        chk("f1_underflow", underflow, 0);

        // Output stall of 3 cycles in the middle of row 1
        obs.delete(); done_cnt = 0;
        start(11'd4, 11'd3);
        send_row(0, 4);
        push(pix(1, 0));
        push(pix(1, 1));
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = pix(1, 2);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_rd_en", 32'(buf_rd_en), 32'd0);
            chk("stall_pair", {out_valid, out_prev, out_cur}, {1'b1, pix(0, 1), pix(1, 1)});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push(pix(1, 2));
        push(pix(1, 3));
        send_row(2, 4);
        wait_idle("f2_idle");
        check_pairs(4, 3, 8);
        chk("f2_done_cnt", done_cnt, 1);

        // Full-width 2-row frame with ramp data
        obs.delete(); done_cnt = 0; occ_max = 0;
        start(11'(MAXR), 11'd2);
        for (int i = 0; i < MAXR; i++) push(8'(i));
        for (int i = 0; i < MAXR; i++) push(8'(i + 7));
        wait_idle("ramp_idle");
        chk("ramp_count", obs.size(), MAXR);
        errs = 0;
        for (int k = 0; k < obs.size(); k++)
            if (obs[k] !== {8'(k), 8'(k + 7), (k == MAXR - 1), 1'b1}) errs++;
        chk("ramp_pair_errs", errs, 0);
        chk("ramp_occ_peak", occ_max, MAXR);
        chk("ramp_done_cnt", done_cnt, 1);

        // Illegal configurations are rejected without leaving IDLE
        start(11'd0, 11'd3);
        @(negedge clk);
        chk("len0_err_busy", {cfg_err, busy}, 32'b10);
        @(posedge clk); #1;
        start(11'd4, 11'd1);
        @(negedge clk);
        chk("rows1_err_busy", {cfg_err, busy}, 32'b10);
        @(posedge clk); #1;
        start(11'd8, 11'd3);
        @(negedge clk);
        chk("legal_clears_err", {cfg_err, busy}, 32'b01);
        @(posedge clk); #1;

        // Mid-frame frame_start flushes the buffered row
        obs.delete(); done_cnt = 0;
        send_row(0, 8);
        for (int c = 0; c < 5; c++) push(pix(1, c));
        repeat (2) begin @(posedge clk); #1; end
        rd_cnt = 0;
        start(11'd8, 11'd3);
        wait_idle("flush_idle");
        chk("flush_reads", rd_cnt, 8);
        chk("flush_done_cnt", done_cnt, 1);
        chk("flush_cfg_err", 32'(cfg_err), 32'd1);
        chk("flush_occ", 32'(dut.occ_r), 32'd0);
        check_pairs(8, 3, 5);

        // Asynchronous reset in the middle of row 1, then a clean frame
        start(11'd4, 11'd3);
        send_row(0, 4);
        push(pix(1, 0));
        push(pix(1, 1));
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {in_ready, buf_wr_en, buf_rd_en, out_valid, out_cur, out_prev,
            out_col_last, out_row_last, frame_done, busy, cfg_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        obs.delete(); done_cnt = 0;
        @(posedge clk); #1;
        start(11'd4, 11'd3);
        for (int r = 0; r < 3; r++) send_row(r, 4);
        wait_idle("f3_idle");
        check_pairs(4, 3, 8);
        chk("f3_done_cnt", done_cnt, 1);
        chk("f3_underflow", underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
